univ_shift_reg: RTL and testbench

- Parametrised successor to the single-bit async-reset D flip-flop: a WIDTH-bit universal shift register with async active-low reset to a parameterised value.
- Modes: hold, shift right, shift left and parallel load, plus a shift counter and a done flag.
- Serves as the datapath register for the lab serialiser/deserialiser and LED-chaser designs.

---
 rtl/univ_shift_reg.sv | 116 +++++++++++
 tb/tb_univ_shift_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : WIDTH-bit universal shift register (hold / shift right /
//            shift left / parallel load) with a saturating shift counter
//            and a registered done flag. Asynchronous active-low reset
//            loads RST_VAL.
// Options  : define SHREG_ROTATE_EN to let rot=1 turn shifts into rotates.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         sin_r,
  input  logic                         sin_l,
  input  logic                         rot,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_r,
  output logic                         sout_l,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         done
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH);

  localparam logic [1:0] C_MODE_HOLD = 2'b00;
  localparam logic [1:0] C_MODE_SHR  = 2'b01;
  localparam logic [1:0] C_MODE_SHL  = 2'b10;
  localparam logic [1:0] C_MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_shift;
  logic             w_in_r;
  logic             w_in_l;

`ifdef SHREG_ROTATE_EN
  // Rotating feeds the outgoing bit back in place of the serial input.
  always_comb begin
    w_in_r = rot ? r_q[0]       : sin_r;
    w_in_l = rot ? r_q[WIDTH-1] : sin_l;
  end
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;

  // Without rotate support the serial inputs always enter the register.
  always_comb begin
    w_in_r = sin_r;
    w_in_l = sin_l;
  end
`endif

  // Next register contents and next shift count for the selected mode.
  always_comb begin
    w_q_nxt   = r_q;
    w_cnt_nxt = r_cnt;
    w_shift   = 1'b0;
    case (mode)
      C_MODE_HOLD: begin
        w_q_nxt = r_q;
      end
      C_MODE_SHR: begin
        w_q_nxt = {w_in_r, r_q[WIDTH-1:1]};
        w_shift = 1'b1;
      end
      C_MODE_SHL: begin
        w_q_nxt = {r_q[WIDTH-2:0], w_in_l};
        w_shift = 1'b1;
      end
      C_MODE_LOAD: begin
        w_q_nxt   = d;
        w_cnt_nxt = '0;
      end
      default: begin
        w_q_nxt = r_q;
      end
    endcase
    // Count saturates at WIDTH; shifting itself carries on past that.
    if (w_shift && (r_cnt != C_CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // State register; done is derived from the next count so it rises with the WIDTH-th shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q    <= RST_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (en) begin
      r_q    <= w_q_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= (w_cnt_nxt == C_CNT_MAX);
    end
  end

  assign q      = r_q;
  assign cnt    = r_cnt;
  assign done   = r_done;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=8'hA5)
//            with a cycle model and directed vectors. Rotate vectors run
//            only when SHREG_ROTATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

  localparam int         W    = 8;
  localparam logic [7:0] RSTV = 8'hA5;
`ifdef SHREG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic       rot = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [3:0] cnt;
  logic       done;

  int checks = 0;
  int fails  = 0;
  bit chk_on = 1'b0;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(RSTV)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .sin_r(sin_r),
    .sin_l(sin_l), .rot(rot), .d(d), .q(q), .sout_r(sout_r),
    .sout_l(sout_l), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: value arithmetic on bytes, counter as a plain integer.
  logic [7:0] m_q;
  int         m_cnt;
  bit         m_done;

  always @(posedge clk or negedge rstn) begin
    int nc;
    if (!rstn) begin
      m_q    <= RSTV;
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (en) begin
      nc = m_cnt;
      case (mode)
        2'd1: begin
          if (ROT_EN && rot) m_q <= (m_q >> 1) | (8'(m_q % 2) << 7);
          else               m_q <= (m_q >> 1) | (8'(sin_r) << 7);
          nc = (m_cnt + 1 > W) ? W : m_cnt + 1;
        end
        2'd2: begin
          if (ROT_EN && rot) m_q <= 8'(m_q * 2) | 8'(m_q / 128);
          else               m_q <= 8'(m_q * 2) | 8'(sin_l);
          nc = (m_cnt + 1 > W) ? W : m_cnt + 1;
        end
        2'd3: begin
          m_q <= d;
          nc  = 0;
        end
        default: ;
      endcase
      m_cnt  <= nc;
      m_done <= (nc == W);
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_q",      int'(q),      int'(m_q));
      cmp("model_cnt",    int'(cnt),    m_cnt);
      cmp("model_done",   int'(done),   int'(m_done));
      cmp("model_sout_r", int'(sout_r), int'(m_q[0]));
      cmp("model_sout_l", int'(sout_l), int'(m_q[7]));
    end
  end

  task automatic step(input logic e, input logic [1:0] m, input logic sr,
                      input logic sl, input logic r, input logic [7:0] dd);
    en = e; mode = m; sin_r = sr; sin_l = sl; rot = r; d = dd;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sr [8];

  initial begin
    exp_sr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset asserted mid-cycle takes effect immediately.
    #3 rstn = 1'b0;
    #1;
    cmp("rst_q",    int'(q),    32'hA5);
    cmp("rst_cnt",  int'(cnt),  0);
    cmp("rst_done", int'(done), 0);
    chk_on = 1'b1;
    #8 rstn = 1'b1;
    @(posedge clk); #1;

    // Hold for five cycles.
    for (int i = 0; i < 5; i++) step(1, 2'b00, 1, 1, 0, 8'hFF);
    cmp("hold_q", int'(q), 32'hA5);

    // Load then shift right with zeros in.
    step(1, 2'b11, 0, 0, 0, 8'b1011_0001);
    for (int i = 0; i < 8; i++) begin
      cmp($sformatf("shr_sout_r%0d", i), int'(sout_r), int'(exp_sr[i]));
      step(1, 2'b01, 0, 0, 0, 8'h00);
    end
    cmp("shr_q",    int'(q),    0);
    cmp("shr_cnt",  int'(cnt),  8);
    cmp("shr_done", int'(done), 1);

    // Shift left with ones in, past saturation.
    step(1, 2'b11, 0, 0, 0, 8'h01);
    for (int i = 0; i < 7; i++) step(1, 2'b10, 0, 1, 0, 8'h00);
    cmp("shl7_done", int'(done), 0);
    step(1, 2'b10, 0, 1, 0, 8'h00);
    cmp("shl8_q",    int'(q),    32'hFF);
    cmp("shl8_cnt",  int'(cnt),  8);
    cmp("shl8_done", int'(done), 1);
    step(1, 2'b10, 0, 1, 0, 8'h00);
    step(1, 2'b10, 0, 1, 0, 8'h00);
    cmp("shl10_cnt",  int'(cnt),  8);
    cmp("shl10_done", int'(done), 1);
    step(1, 2'b11, 0, 0, 0, 8'h3C);
    cmp("ld_q",    int'(q),    32'h3C);
    cmp("ld_cnt",  int'(cnt),  0);
    cmp("ld_done", int'(done), 0);

    // Enable gating.
    step(1, 2'b11, 0, 0, 0, 8'hF0);
    step(1, 2'b01, 1, 0, 0, 8'h00);
    cmp("en1_q", int'(q), 32'hF8); cmp("en1_cnt", int'(cnt), 1);
    step(0, 2'b01, 1, 0, 0, 8'h00);
    cmp("en2_q", int'(q), 32'hF8); cmp("en2_cnt", int'(cnt), 1);
    step(1, 2'b01, 1, 0, 0, 8'h00);
    cmp("en3_q", int'(q), 32'hFC); cmp("en3_cnt", int'(cnt), 2);
    step(0, 2'b01, 1, 0, 0, 8'h00);
    cmp("en4_q", int'(q), 32'hFC); cmp("en4_cnt", int'(cnt), 2);

    // Reset pulse mid-shift.
    step(1, 2'b11, 0, 0, 0, 8'h5A);
    for (int i = 0; i < 5; i++) step(1, 2'b01, 0, 0, 0, 8'h00);
    cmp("pre_rst_cnt", int'(cnt), 5);
    #2 rstn = 1'b0;
    #3 rstn = 1'b1;
    cmp("midrst_q",   int'(q),   32'hA5);
    cmp("midrst_cnt", int'(cnt), 0);
    step(1, 2'b01, 0, 0, 0, 8'h00);
    cmp("post_rst_q",   int'(q),   32'h52);
    cmp("post_rst_cnt", int'(cnt), 1);

    // Mixed left/right shifts all count.
    step(1, 2'b11, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b10, 0, 1, 0, 8'h00);
      step(1, 2'b01, 1, 0, 0, 8'h00);
    end
    cmp("mix_cnt",  int'(cnt),  8);
    cmp("mix_done", int'(done), 1);

`ifdef SHREG_ROTATE_EN
    // Rotates count exactly like shifts.
    step(1, 2'b11, 0, 0, 0, 8'h81);
    step(1, 2'b10, 0, 0, 1, 8'h00);
    cmp("rotl_q", int'(q), 32'h03);
    step(1, 2'b01, 0, 0, 1, 8'h00);
    step(1, 2'b01, 0, 0, 1, 8'h00);
    cmp("rotr_q", int'(q), 32'hC0);
    for (int i = 0; i < 4; i++) step(1, 2'b01, 0, 0, 1, 8'h00);
    cmp("rot7_done", int'(done), 0);
    step(1, 2'b01, 0, 0, 1, 8'h00);
    cmp("rot8_done", int'(done), 1);
`endif

    step(0, 2'b00, 0, 0, 0, 8'h00);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
